// File: rtl/meter_pkg.sv
// Shared helpers for the peak meter: constant log2, rectify-mode codes and the
// magnitude-to-bar-index mapping used by every channel.
package meter_pkg;

    localparam int HALF_WAVE = 0;
    localparam int FULL_WAVE = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Scales a magnitude onto 0..led_w lit LEDs; full scale saturates at led_w.
    function automatic int bar_index(input int mag, input int led_w, input int mag_w);
        longint prod;
        int     result;
        prod   = (longint'(mag) * longint'(led_w + 1)) >>> mag_w;
        result = (prod > longint'(led_w)) ? led_w : int'(prod);
        return result;
    endfunction

endpackage

// File: rtl/peak_meter_if.sv
// Sample-side bundle of the peak meter: tick enable plus the ADC sample strobe.
interface peak_meter_if #(
    parameter int CH_W   = 2,
    parameter int DATA_W = 12
);
    logic              tick;
    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;

    modport master (output tick, in_valid, in_ch, in_data);
    modport slave  (input  tick, in_valid, in_ch, in_data);
endinterface

// File: rtl/meter_channel.sv
// One meter channel: window maximum, decaying bar level, held peak marker and
// the LED pattern those values will show once the current window closes.
module meter_channel
    import meter_pkg::*;
#(
    parameter int MAG_W      = 11,
    parameter int LED_W      = 8,
    parameter int DECAY_STEP = 64,
    parameter int HOLD_WIN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             close,
    input  logic             acc,
    input  logic [MAG_W-1:0] mag,
    output logic [LED_W-1:0] leds_d
);
    localparam int HOLD_W = (clog2(HOLD_WIN + 1) > 0) ? clog2(HOLD_WIN + 1) : 1;

    logic [MAG_W-1:0]  wmax_q, wmax_d, wmax_new;
    logic [MAG_W-1:0]  level_q, level_d, level_dec;
    logic [MAG_W-1:0]  peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    int                b_level;
    int                b_peak;

    always_comb begin
        wmax_new  = (acc && (mag > wmax_q)) ? mag : wmax_q;
        wmax_d    = wmax_new;
        level_d   = level_q;
        peak_d    = peak_q;
        hold_d    = hold_q;
        level_dec = '0;
        if (int'(level_q) > DECAY_STEP) begin
            level_dec = level_q - MAG_W'(DECAY_STEP);
        end
        if (close) begin
            wmax_d  = '0;
            level_d = (wmax_new > level_dec) ? wmax_new : level_dec;
            // The hold count includes the capture window itself, so the marker
            // is shown for HOLD_WIN frames before it drops onto the bar.
            if (wmax_new >= peak_q) begin
                peak_d = wmax_new;
                hold_d = HOLD_W'(HOLD_WIN);
            end else if (hold_q > HOLD_W'(1)) begin
                hold_d = hold_q - HOLD_W'(1);
            end else begin
                hold_d = '0;
                peak_d = level_d;
            end
        end
        b_level = bar_index(int'(level_d), LED_W, MAG_W);
        b_peak  = bar_index(int'(peak_d), LED_W, MAG_W);
    end

    genvar gi;
    generate
        for (gi = 0; gi < LED_W; gi++) begin : g_led
            assign leds_d[gi] = (gi < b_level) || ((b_peak > 0) && (gi == b_peak - 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wmax_q  <= '0;
            level_q <= '0;
            peak_q  <= '0;
            hold_q  <= '0;
        end else begin
            wmax_q  <= wmax_d;
            level_q <= level_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/peak_meter.sv
// Multi-channel LED peak meter: rectifies ADC samples, routes them to per-channel
// meters and publishes all bars together once per measurement window.
module peak_meter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 12,
    parameter int LED_W      = 8,
    parameter int WIN_TICKS  = 512,
    parameter int DECAY_STEP = 64,
    parameter int HOLD_WIN   = 8,
    parameter int FULL_WAVE  = 0,
    localparam int CH_W      = (meter_pkg::clog2(NUM_CH) > 0) ? meter_pkg::clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    in_valid,
    input  logic [CH_W-1:0]         in_ch,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NUM_CH*LED_W-1:0] leds,
    output logic                    frame
);
    localparam int MAG_W = DATA_W - 1;
    localparam int CNT_W = (meter_pkg::clog2(WIN_TICKS) > 0) ? meter_pkg::clog2(WIN_TICKS) : 1;

    logic [MAG_W-1:0]        mag;
    logic                    accept;
    logic                    close;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH*LED_W-1:0] bar_leds;
    logic [NUM_CH*LED_W-1:0] leds_q, leds_d;
    logic                    frame_q, frame_d;
    logic [NUM_CH-1:0]       ch_acc;

    always_comb begin
        mag = '0;
        if (in_data[DATA_W-1]) begin
            mag = in_data[MAG_W-1:0];
        end else if (FULL_WAVE == meter_pkg::FULL_WAVE) begin
            // Below midpoint MID-1-d is just the bitwise inverse of the low bits.
            mag = ~in_data[MAG_W-1:0];
        end
        accept = in_valid && (int'(in_ch) < NUM_CH);
        close  = tick && (cnt_q == CNT_W'(WIN_TICKS - 1));
        cnt_d  = cnt_q;
        if (tick) begin
            cnt_d = close ? '0 : cnt_q + CNT_W'(1);
        end
        leds_d  = close ? bar_leds : leds_q;
        frame_d = close;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_acc[gi] = accept && (in_ch == CH_W'(gi));
            meter_channel #(
                .MAG_W      (MAG_W),
                .LED_W      (LED_W),
                .DECAY_STEP (DECAY_STEP),
                .HOLD_WIN   (HOLD_WIN)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .close  (close),
                .acc    (ch_acc[gi]),
                .mag    (mag),
                .leds_d (bar_leds[gi*LED_W +: LED_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            leds_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            frame_q <= frame_d;
        end
    end

    assign leds  = leds_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_peak_meter.sv
// Directed bench for peak_meter: three builds (half-wave, full-wave, 3-channel)
// share one sample bus and are checked against hand-computed bar patterns.
module tb_peak_meter;

    logic        clk;
    logic        rst;
    logic [31:0] leds_a, leds_fw;
    logic [23:0] leds_3;
    logic        frame_a, frame_fw, frame_3;
    int          checks;
    int          passes;

    logic        v_a  [4];
    logic [1:0]  ch_a [4];
    logic [11:0] d_a  [4];

    peak_meter_if #(.CH_W(2), .DATA_W(12)) sbus ();

    peak_meter #(.NUM_CH(4), .DATA_W(12), .LED_W(8), .WIN_TICKS(4), .DECAY_STEP(256),
                 .HOLD_WIN(2), .FULL_WAVE(0)) dut (
        .clk(clk), .rst(rst), .tick(sbus.tick), .in_valid(sbus.in_valid),
        .in_ch(sbus.in_ch), .in_data(sbus.in_data), .leds(leds_a), .frame(frame_a));

    peak_meter #(.NUM_CH(4), .DATA_W(12), .LED_W(8), .WIN_TICKS(4), .DECAY_STEP(256),
                 .HOLD_WIN(2), .FULL_WAVE(1)) dut_fw (
        .clk(clk), .rst(rst), .tick(sbus.tick), .in_valid(sbus.in_valid),
        .in_ch(sbus.in_ch), .in_data(sbus.in_data), .leds(leds_fw), .frame(frame_fw));

    peak_meter #(.NUM_CH(3), .DATA_W(12), .LED_W(8), .WIN_TICKS(4), .DECAY_STEP(256),
                 .HOLD_WIN(2), .FULL_WAVE(0)) dut3 (
        .clk(clk), .rst(rst), .tick(sbus.tick), .in_valid(sbus.in_valid),
        .in_ch(sbus.in_ch), .in_data(sbus.in_data), .leds(leds_3), .frame(frame_3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        sbus.tick     = 1'b0;
        sbus.in_valid = 1'b0;
        sbus.in_ch    = 2'd0;
        sbus.in_data  = 12'd0;
    endtask

    task automatic clear_slots();
        for (int k = 0; k < 4; k++) begin
            v_a[k] = 1'b0; ch_a[k] = 2'd0; d_a[k] = 12'd0;
        end
    endtask

    task automatic set_slot(input int k, input logic [1:0] ch, input logic [11:0] d);
        v_a[k] = 1'b1; ch_a[k] = ch; d_a[k] = d;
    endtask

    task automatic do_reset();
        idle_bus();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Runs one full window (tick every cycle) and returns the frame seen after each edge.
    task automatic window(output logic [3:0] fpat);
        for (int k = 0; k < 4; k++) begin
            sbus.tick     = 1'b1;
            sbus.in_valid = v_a[k];
            sbus.in_ch    = ch_a[k];
            sbus.in_data  = d_a[k];
            step();
            fpat[k] = frame_a;
        end
        idle_bus();
        clear_slots();
    endtask

    task automatic test_reset();
        logic [3:0] fp;
        rst = 1'b1;
        sbus.tick = 1'b1; sbus.in_valid = 1'b1; sbus.in_ch = 2'd0; sbus.in_data = 12'hFFF;
        step();
        rst = 1'b0;
        idle_bus();
        checks++; if (leds_a !== 32'h0) $display("FAIL reset_leds: got %h expected %h", leds_a, 32'h0); else passes++;
        checks++; if (frame_a !== 1'b0) $display("FAIL reset_frame: got %b expected 0", frame_a); else passes++;
        checks++; if (leds_3 !== 24'h0) $display("FAIL reset_leds3: got %h expected %h", leds_3, 24'h0); else passes++;
        window(fp);
        checks++; if (fp !== 4'b1000) $display("FAIL reset_first_window_frames: got %b expected %b", fp, 4'b1000); else passes++;
        checks++; if (leds_a !== 32'h0) $display("FAIL reset_sample_ignored: got %h expected %h", leds_a, 32'h0); else passes++;
        $display("test_reset done: leds=%h frame_pattern=%b", leds_a, fp);
    endtask

    task automatic test_midwindow_reset();
        logic [3:0] fp;
        sbus.tick = 1'b1; sbus.in_valid = 1'b1; sbus.in_ch = 2'd0; sbus.in_data = 12'hFFF;
        step();
        sbus.in_valid = 1'b0;
        step();
        do_reset();
        checks++; if (leds_a !== 32'h0 || frame_a !== 1'b0)
            $display("FAIL midreset_outputs: got leds=%h frame=%b expected 0/0", leds_a, frame_a); else passes++;
        window(fp);
        checks++; if (fp !== 4'b1000) $display("FAIL midreset_window_len: got %b expected %b", fp, 4'b1000); else passes++;
        checks++; if (leds_a !== 32'h0) $display("FAIL midreset_discard: got %h expected %h", leds_a, 32'h0); else passes++;
        $display("test_midwindow_reset done: leds=%h frame_pattern=%b", leds_a, fp);
    endtask

    task automatic test_attack_decay();
        logic [3:0] fp;
        logic [7:0] exp_bar [4];
        exp_bar[0] = 8'hFF; exp_bar[1] = 8'hFF; exp_bar[2] = 8'h3F; exp_bar[3] = 8'h1F;
        do_reset();
        set_slot(0, 2'd0, 12'd4095);
        for (int w = 0; w < 4; w++) begin
            window(fp);
            checks++; if (fp !== 4'b1000) $display("FAIL decay_frames_w%0d: got %b expected %b", w, fp, 4'b1000); else passes++;
            checks++; if (leds_a !== {24'h0, exp_bar[w]})
                $display("FAIL decay_leds_w%0d: got %h expected %h", w, leds_a, {24'h0, exp_bar[w]}); else passes++;
            if (w == 0) begin
                checks++; if (leds_fw !== 32'hFF) $display("FAIL attack_leds_fw: got %h expected %h", leds_fw, 32'hFF); else passes++;
                checks++; if (leds_3 !== 24'hFF) $display("FAIL attack_leds3: got %h expected %h", leds_3, 24'hFF); else passes++;
            end
            $display("decay window %0d: leds=%h frame_pattern=%b", w, leds_a, fp);
        end
    endtask

    task automatic test_rectify();
        logic [3:0] fp;
        do_reset();
        set_slot(1, 2'd1, 12'd0);
        window(fp);
        checks++; if (leds_a !== 32'h0) $display("FAIL rect_half_zero: got %h expected %h", leds_a, 32'h0); else passes++;
        checks++; if (leds_fw !== 32'h0000FF00) $display("FAIL rect_full_zero: got %h expected %h", leds_fw, 32'h0000FF00); else passes++;
        do_reset();
        set_slot(2, 2'd1, 12'd1024);
        window(fp);
        checks++; if (leds_a !== 32'h0) $display("FAIL rect_half_1024: got %h expected %h", leds_a, 32'h0); else passes++;
        checks++; if (leds_fw !== 32'h00000F00) $display("FAIL rect_full_1024: got %h expected %h", leds_fw, 32'h00000F00); else passes++;
        $display("test_rectify done: half=%h full=%h", leds_a, leds_fw);
    endtask

    task automatic test_close_sample();
        logic [3:0] fp;
        do_reset();
        set_slot(3, 2'd2, 12'd3072);
        window(fp);
        checks++; if (leds_a !== 32'h000F0000) $display("FAIL close_sample: got %h expected %h", leds_a, 32'h000F0000); else passes++;
        checks++; if (leds_3 !== 24'h0F0000) $display("FAIL close_sample3: got %h expected %h", leds_3, 24'h0F0000); else passes++;
        do_reset();
        set_slot(1, 2'd3, 12'd4095);
        window(fp);
        checks++; if (leds_3 !== 24'h0) $display("FAIL bad_channel_ignored: got %h expected %h", leds_3, 24'h0); else passes++;
        checks++; if (leds_a !== 32'hFF000000) $display("FAIL ch3_accepted: got %h expected %h", leds_a, 32'hFF000000); else passes++;
        $display("test_close_sample done: leds=%h leds3=%h", leds_a, leds_3);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  fp;
        logic [31:0] exp_l [3];
        exp_l[0] = 32'h3F000001; exp_l[1] = 32'hFF000001; exp_l[2] = 32'hFF000000;
        do_reset();
        set_slot(0, 2'd3, 12'd2560); set_slot(1, 2'd3, 12'd3584);
        set_slot(2, 2'd3, 12'd2560); set_slot(3, 2'd0, 12'd2304);
        for (int w = 0; w < 3; w++) begin
            if (w == 1) set_slot(0, 2'd3, 12'd4095);
            window(fp);
            checks++; if (leds_a !== exp_l[w] || fp !== 4'b1000)
                $display("FAIL b2b_w%0d: got %h/%b expected %h/%b", w, leds_a, fp, exp_l[w], 4'b1000); else passes++;
            $display("back_to_back window %0d: leds=%h", w, leds_a);
        end
    endtask

    task automatic test_tick_gap();
        logic [7:0] fp;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            sbus.tick     = k[0];
            sbus.in_valid = (k == 0);
            sbus.in_ch    = 2'd0;
            sbus.in_data  = 12'd4095;
            step();
            fp[k] = frame_a;
        end
        idle_bus();
        checks++; if (fp !== 8'h80) $display("FAIL tick_gap_frames: got %b expected %b", fp, 8'h80); else passes++;
        checks++; if (leds_a !== 32'hFF) $display("FAIL tick_gap_leds: got %h expected %h", leds_a, 32'hFF); else passes++;
        step();
        checks++; if (frame_a !== 1'b0 || leds_a !== 32'hFF)
            $display("FAIL frame_single_pulse: got %b/%h expected 0/%h", frame_a, leds_a, 32'hFF); else passes++;
        $display("test_tick_gap done: frame_pattern=%b leds=%h", fp, leds_a);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        idle_bus();
        clear_slots();
        step();
        test_reset();
        test_midwindow_reset();
        test_attack_decay();
        test_rectify();
        test_close_sample();
        test_back_to_back();
        test_tick_gap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
